uart_tx_core: RTL and testbench
===============================

Name: uart_tx_core

Overview:
- Synthesizable UART transmitter for the SoC peripheral: accepts bytes over a valid/ready handshake, buffers them in a small FIFO, and serializes each onto tx_o.
- Frame format is 8N1, or 8E1 when parity is enabled.
- Feeds the testbench UART receiver model, whose line format it must match exactly: idle high, start 0, LSB first, optional even-parity bit, one stop bit.

Parameters:
- FIFO_DEPTH, 8, number of byte entries in the TX FIFO (power of 2, >=2).
- PARITY_EN, 0, 1 = insert even-parity bit after data (XOR of the 8 data bits).
- DIV_W, 16, width of baud divisor.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- cfg_en_i  in  1  transmitter enable; 0 = do not start new frames
- cfg_div_i  in  DIV_W  clk cycles per bit
- tx_data_i  in  8  byte to send
- tx_valid_i  in  1  tx_data_i valid
- tx_ready_o  out  1  FIFO can accept (count < FIFO_DEPTH)
- tx_o  out  1  serial line
- busy_o  out  1  frame in progress or FIFO non-empty
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Clock and reset: one clock domain (clk); rst_n asynchronous assert, active low, synchronous deassert assumed upstream.
- Reset values:
  - tx_o=1
  - tx_ready_o=1
  - busy_o=0
  - fifo_count_o=0
  - FSM=IDLE
  - bit timer, bit index and shift register cleared
- Reset mid-frame: line returns high immediately (asynchronous), FIFO contents are discarded, and no partial frame resumes.
- Handshake:
  - A byte is accepted on a rising edge where tx_valid_i && tx_ready_o.
  - tx_data_i must hold while valid && !ready.
  - No combinational path from tx_valid_i to tx_ready_o.
- FIFO:
  - Push and pop may occur in the same cycle; count stays unchanged.
  - When full, tx_ready_o=0 even if a pop occurs that cycle (no bypass).
  - Pointers wrap modulo FIFO_DEPTH.
  - Writes while full are ignored; upstream must respect ready.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_o=1. If cfg_en_i && FIFO non-empty: pop the head into the shift register, latch cfg_div_i into div_q, load the timer, go to START. The pop happens on the edge after the push edge, so tx_o falls 1 cycle after the first accept into an empty FIFO.
  - START: tx_o=0 for div_q cycles, then go to DATA with bit index 0.
  - DATA: tx_o=shift[0] for div_q cycles per bit, shifting right each bit. After bit 7, go to PARITY if PARITY_EN, else to STOP.
  - PARITY: tx_o = XOR of the 8 data bits, for div_q cycles.
  - STOP: tx_o=1 for div_q cycles. Then, if cfg_en_i && FIFO non-empty, pop and go directly to START with zero idle gap; else go to IDLE.
- Bit timer:
  - Down-counter loaded with div_q-1, decremented each cycle; the bit ends when it reaches 0.
  - cfg_div_i of 0 is treated as 1.
  - div_q is latched only at frame start, so changing cfg_div_i mid-frame affects the next frame only.
- Frame length: exactly (10+PARITY_EN)*div_q cycles; back-to-back frames are contiguous.
- cfg_en_i deasserted mid-frame: the current frame completes, then the FSM returns to IDLE and the FIFO keeps its contents. Re-enabling resumes with the head byte.
- busy_o = (state != IDLE) || (fifo_count != 0), registered from next-state values so it rises the cycle after the first accept.

Decomposition:
- Package uart_pkg:
  - uart_tx_state_e enum (IDLE, START, DATA, PARITY, STOP)
  - UART_DATA_BITS=8
  - UART_IDLE_LEVEL=1'b1, UART_START_LEVEL=1'b0
  - helper function even_parity(byte)
- Sub-module uart_tx_fifo:
  - synchronous FIFO with push/pop, count, full/empty
  - depth FIFO_DEPTH, width 8
  - reusable by a later RX block
- uart_tx_core instantiates uart_tx_fifo plus the FSM, bit timer and shift register.

Test Plan:
- Basic 8N1 (PARITY_EN=0, cfg_div=16): push 0x55 → tx_o falls 1 cycle after accept; 160 cycles total; sampled bits at mid-bit read 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop); busy_o drops the cycle after the stop bit ends.
- Parity (PARITY_EN=1, cfg_div=8): send 0x07 → parity bit=1, frame 88 cycles; send 0x03 → parity bit=0; bench receiver (BIT_PERIOD=8 clk) reports no parity error.
- Back-to-back and full (FIFO_DEPTH=8, cfg_div=4):
  - hold valid for 12 bytes 0x00..0x0B → tx_ready_o low after 9 accepts (8 queued + 1 already popped into the shifter)
  - all 12 bytes appear in order with no idle cycles between the stop bit and the next start bit
- Enable gating: cfg_en_i=0, push 3 bytes → tx_o stays 1, fifo_count_o=3, busy_o=1. Raise cfg_en_i → 3 frames are sent. Drop cfg_en_i mid-second frame → second frame completes, third is held until re-enabled.
- Divisor change: start a frame with cfg_div=10 and switch to 20 at cycle 30 → current frame stays 100 cycles, next frame is 200 cycles. cfg_div=0 → 1 cycle per bit.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 → tx_o=1 asynchronously (same timestep). After release: fifo_count_o=0, tx_ready_o=1, no further edges on tx_o.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, line levels and parity helper.
package uart_pkg;

  localparam int   UART_DATA_BITS   = 8;
  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with occupancy count; full blocks pushes with no pop bypass.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [DATA_W-1:0]            wdata,
  input  logic                         pop,
  output logic [DATA_W-1:0]            rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(FIFO_DEPTH):0]  count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: byte FIFO feeding a start/data/parity/stop serializer.
// The divisor is captured per frame so cfg_div_i changes only affect later frames.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int PARITY_EN  = 0,
  parameter int DIV_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_en_i,
  input  logic [DIV_W-1:0]             cfg_div_i,
  input  logic [UART_DATA_BITS-1:0]    tx_data_i,
  input  logic                         tx_valid_i,
  output logic                         tx_ready_o,
  output logic                         tx_o,
  output logic                         busy_o,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count_o
);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = $clog2(UART_DATA_BITS);

  logic                      push;
  logic                      pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_rdata;
  logic [CW-1:0]             fifo_count;
  logic [CW-1:0]             count_d;

  uart_tx_state_e            state_q, state_d;
  logic [DIV_W-1:0]          div_q, div_d;
  logic [DIV_W-1:0]          timer_q, timer_d;
  logic [DIV_W-1:0]          div_eff;
  logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      par_q, par_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      bit_end;
  logic                      launch;

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (UART_DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (tx_data_i),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Ready depends only on registered occupancy, never on tx_valid_i.
  assign tx_ready_o   = !fifo_full;
  assign push         = tx_valid_i && !fifo_full;
  assign pop          = launch;
  assign fifo_count_o = fifo_count;
  assign tx_o         = tx_q;
  assign busy_o       = busy_q;

  assign div_eff = (cfg_div_i == '0) ? DIV_W'(1) : cfg_div_i;
  assign bit_end = (timer_q == '0);

  always_comb begin
    count_d = fifo_count;
    if (push && !pop)      count_d = fifo_count + 1'b1;
    else if (pop && !push) count_d = fifo_count - 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    launch    = 1'b0;

    if (state_q != IDLE) timer_d = bit_end ? (div_q - 1'b1) : (timer_q - 1'b1);

    case (state_q)
      IDLE:   if (cfg_en_i && !fifo_empty) launch = 1'b1;
      START:  if (bit_end) begin
                state_d   = DATA;
                bit_idx_d = '0;
              end
      DATA:   if (bit_end) begin
                shift_d = shift_q >> 1;
                if (bit_idx_q == IDX_W'(UART_DATA_BITS - 1)) state_d = (PARITY_EN != 0) ? PARITY : STOP;
                else                                         bit_idx_d = bit_idx_q + 1'b1;
              end
      PARITY: if (bit_end) state_d = STOP;
      STOP:   if (bit_end) begin
                if (cfg_en_i && !fifo_empty) launch  = 1'b1;
                else                         state_d = IDLE;
              end
      default: state_d = IDLE;
    endcase

    // Stop-to-start chaining reuses the idle launch path, giving zero gap.
    if (launch) begin
      state_d   = START;
      shift_d   = fifo_rdata;
      par_d     = even_parity(fifo_rdata);
      div_d     = div_eff;
      timer_d   = div_eff - 1'b1;
      bit_idx_d = '0;
    end

    case (state_d)
      START:   tx_d = UART_START_LEVEL;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = UART_IDLE_LEVEL;
    endcase

    busy_d = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= UART_IDLE_LEVEL;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: two instances (8N1 and 8E1), queue scoreboard and line receivers.
module tb_uart_tx_core;
  localparam int DEPTH = 8;
  localparam int DIV_W = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [7:0] data;
    int         div;
  } frame_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n      [2];
  logic             cfg_en     [2];
  logic [DIV_W-1:0] cfg_div    [2];
  logic [7:0]       tx_data    [2];
  logic             tx_valid   [2];
  logic             tx_ready   [2];
  logic             tx         [2];
  logic             busy       [2];
  logic [CW-1:0]    fifo_count [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fs [2]       = '{0, 0};
  int fd [2]       = '{0, 0};
  int contig [2]   = '{0, 0};
  int last_end [2] = '{-10, -10};
  frame_t q0[$];
  frame_t q1[$];

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    uart_tx_core #(.FIFO_DEPTH(DEPTH), .PARITY_EN(g), .DIV_W(DIV_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n[g]),
      .cfg_en_i     (cfg_en[g]),
      .cfg_div_i    (cfg_div[g]),
      .tx_data_i    (tx_data[g]),
      .tx_valid_i   (tx_valid[g]),
      .tx_ready_o   (tx_ready[g]),
      .tx_o         (tx[g]),
      .busy_o       (busy[g]),
      .fifo_count_o (fifo_count[g])
    );
  end

  function automatic void exp_push(input int i, input logic [7:0] d, input int dv);
    frame_t f;
    f.data = d;
    f.div  = dv;
    if (i == 0) q0.push_back(f);
    else        q1.push_back(f);
  endfunction

  function automatic int exp_size(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic frame_t exp_pop(input int i);
    if (i == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic void exp_clear(input int i);
    if (i == 0) q0.delete();
    else        q1.delete();
  endfunction

  // Line level of bit slot b of a frame: start, 8 data LSB first, [even parity], stop.
  function automatic logic line_level(input int par, input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (b == 9 && par != 0) return ^d;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Receiver: every cycle of a frame is compared against the expected level.
  task automatic monitor(input int i);
    frame_t     f;
    int         n;
    int         bidx;
    logic [7:0] rx;
    logic       shape_ok;
    logic       aborted;
    forever begin
      @(negedge clk);
      if (rst_n[i] === 1'b1 && tx[i] === 1'b0) begin
        if (exp_size(i) == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_start dut%0d cycle=%0d got=line_low want=idle", i, cyc);
          while (rst_n[i] === 1'b1 && tx[i] === 1'b0) @(negedge clk);
        end else begin
          f = exp_pop(i);
          n = (10 + i) * f.div;
          fs[i]++;
          if (cyc == last_end[i]) contig[i]++;
          shape_ok = 1'b1;
          aborted  = 1'b0;
          rx       = '0;
          for (int c = 0; c < n; c++) begin
            if (c > 0) @(negedge clk);
            if (rst_n[i] !== 1'b1) begin
              aborted = 1'b1;
              break;
            end
            bidx = c / f.div;
            if (tx[i] !== line_level(i, f.data, bidx)) shape_ok = 1'b0;
            if (bidx >= 1 && bidx <= 8 && (c % f.div) == f.div / 2) rx[bidx-1] = tx[i];
          end
          if (!aborted) begin
            last_end[i] = cyc + 1;
            fd[i]++;
            total++;
            if (!shape_ok || rx !== f.data) begin
              bad++;
              $display("FAIL frame dut%0d got=%02h want=%02h line_ok=%0b div=%0d", i, rx, f.data, shape_ok, f.div);
            end
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic push(input int i, input logic [7:0] d, input int dv);
    logic acc;
    acc = 1'b0;
    tx_data[i]  = d;
    tx_valid[i] = 1'b1;
    for (int k = 0; k < 4000 && !acc; k++) begin
      acc = tx_ready[i];
      step(1);
    end
    tx_valid[i] = 1'b0;
    if (acc) exp_push(i, d, dv);
    else begin
      total++;
      bad++;
      $display("FAIL push_timeout dut%0d got=no_accept want=accept", i);
    end
  endtask

  task automatic wait_frames(input int i, input int target, input int budget);
    for (int k = 0; k < budget && fd[i] < target; k++) step(1);
    chk($sformatf("frames_done_dut%0d", i), fd[i], target);
  endtask

  initial begin
    int   k;
    int   n_acc;
    int   base;
    int   base_c;
    int   bs;
    int   glitches;
    logic acc;

    for (int i = 0; i < 2; i++) begin
      rst_n[i]    = 1'b0;
      cfg_en[i]   = 1'b1;
      cfg_div[i]  = 16'd16;
      tx_data[i]  = '0;
      tx_valid[i] = 1'b0;
    end
    step(3);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_tx_dut%0d", i), tx[i], 1);
      chk($sformatf("reset_ready_dut%0d", i), tx_ready[i], 1);
      chk($sformatf("reset_busy_dut%0d", i), busy[i], 0);
      chk($sformatf("reset_count_dut%0d", i), fifo_count[i], 0);
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    step(2);

    // Basic 8N1 frame at 16 clocks per bit.
    push(0, 8'h55, 16);
    chk("t1_tx_high_at_accept", tx[0], 1);
    chk("t1_busy_after_accept", busy[0], 1);
    chk("t1_count_after_accept", fifo_count[0], 1);
    step(1);
    chk("t1_tx_fall", tx[0], 0);
    k = 0;
    while (busy[0] === 1'b1 && k < 1000) begin
      step(1);
      k++;
    end
    chk("t1_busy_cycles", k, 160);
    wait_frames(0, 1, 50);

    // Even parity frames, second one chained.
    cfg_div[1] = 16'd8;
    push(1, 8'h07, 8);
    push(1, 8'h03, 8);
    wait_frames(1, 2, 400);
    chk("t2_contiguous", contig[1], 1);

    // Back-to-back fill with valid held high.
    cfg_div[0]  = 16'd4;
    base        = fd[0];
    base_c      = contig[0];
    n_acc       = 0;
    k           = 0;
    tx_valid[0] = 1'b1;
    while (n_acc < 12 && k < 5000) begin
      tx_data[0] = 8'(n_acc);
      acc = tx_ready[0];
      step(1);
      k++;
      if (acc) begin
        exp_push(0, 8'(n_acc), 4);
        n_acc++;
        if (n_acc == 9) begin
          chk("t3_ready_low_after_9", tx_ready[0], 0);
          chk("t3_count_full", fifo_count[0], 8);
        end
      end
    end
    tx_valid[0] = 1'b0;
    chk("t3_accepted", n_acc, 12);
    wait_frames(0, base + 12, 1000);
    chk("t3_contiguous", contig[0] - base_c, 11);

    // Enable gating.
    cfg_en[1]  = 1'b0;
    cfg_div[1] = 16'd6;
    base       = fd[1];
    bs         = fs[1];
    for (int j = 0; j < 3; j++) push(1, 8'($urandom), 6);
    step(20);
    chk("t4_tx_idle_disabled", tx[1], 1);
    chk("t4_count_held", fifo_count[1], 3);
    chk("t4_busy_disabled", busy[1], 1);
    cfg_en[1] = 1'b1;
    k = 0;
    while (fs[1] < bs + 2 && k < 500) begin
      step(1);
      k++;
    end
    chk("t4_second_started", fs[1], bs + 2);
    step(20);
    cfg_en[1] = 1'b0;
    wait_frames(1, base + 2, 300);
    step(100);
    chk("t4_third_held", fd[1], base + 2);
    chk("t4_count_one", fifo_count[1], 1);
    chk("t4_line_idle", tx[1], 1);
    cfg_en[1] = 1'b1;
    wait_frames(1, base + 3, 300);
    chk("t4_count_drained", fifo_count[1], 0);

    // Divisor captured per frame; zero treated as one.
    cfg_div[0] = 16'd10;
    base       = fd[0];
    base_c     = contig[0];
    push(0, 8'($urandom), 10);
    push(0, 8'($urandom), 20);
    step(28);
    cfg_div[0] = 16'd20;
    wait_frames(0, base + 2, 1000);
    chk("t5_contiguous", contig[0] - base_c, 1);
    cfg_div[0] = 16'd0;
    push(0, 8'($urandom), 1);
    wait_frames(0, base + 3, 100);

    // Reset during data bit 3 of 0xA5 (a low bit), with one byte still queued.
    cfg_div[0] = 16'd16;
    push(0, 8'hA5, 16);
    push(0, 8'h3C, 16);
    step(70);
    @(negedge clk);
    chk("t6_line_low_before_reset", tx[0], 0);
    #1;
    rst_n[0] = 1'b0;
    exp_clear(0);
    #1;
    chk("t6_tx_async_high", tx[0], 1);
    step(3);
    chk("t6_count_cleared", fifo_count[0], 0);
    chk("t6_ready_after_reset", tx_ready[0], 1);
    chk("t6_busy_after_reset", busy[0], 0);
    rst_n[0] = 1'b1;
    glitches = 0;
    for (int j = 0; j < 200; j++) begin
      step(1);
      if (tx[0] !== 1'b1) glitches++;
    end
    chk("t6_no_edges_after_reset", glitches, 0);
    chk("t6_count_after_release", fifo_count[0], 0);

    chk("final_queue_dut0", exp_size(0), 0);
    chk("final_queue_dut1", exp_size(1), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
